// File: rtl/casez_lut_sig.sv
// Registered nested-casez LUT decoder with a MISR signature accumulator.
// Define CASEZ_LUT_SIG_XOR_EN to XOR each mode-2'b00 lane with in_data[0].
module casez_lut_sig #(
  parameter int             IN_W  = 24,
  parameter int             OUT_W = 1,
  parameter int             SIG_W = 64,
  parameter int             CNT_W = 16,
  parameter logic [1023:0]  LUT   = 1024'h29_8593_2C4D
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [SIG_W-1:0] sig,
  output logic             done
);

  localparam int LUT_IDX_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [SIG_W-1:0]   sig_q;
  logic               done_q;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic [CNT_W-1:0]   upd_cnt_q;
  logic [CNT_W-1:0]   num_q;

  logic [5:0]           entry;
  logic [LUT_IDX_W-1:0] lut_base;
  logic [OUT_W-1:0]     out_data_d;
  logic [SIG_W-1:0]     sig_d;
  logic [CNT_W-1:0]     acc_cnt_inc;
  logic [CNT_W-1:0]     upd_cnt_inc;
  logic                 accept;

  // Only the mode, bit 4 and the low selector bits take part in the decode.
  logic unused_in_bits;
  assign unused_in_bits = ^{in_data[IN_W-1:18], in_data[15:5], in_data[3]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    entry = '0;
    casez (in_data[17:16])
      2'b00:   entry = {3'b000, in_data[2:0]};
      2'b01:   entry = 6'd10 + {3'b000, in_data[2:0]};
      2'b1?:   entry = (in_data[4] ? 6'd20 : 6'd30) + {3'b000, in_data[2:0]};
      default: entry = '0;
    endcase
    lut_base   = LUT_IDX_W'(entry) * LUT_IDX_W'(OUT_W);
    out_data_d = LUT[lut_base +: OUT_W];
`ifdef CASEZ_LUT_SIG_XOR_EN
    if (in_data[17:16] == 2'b00) out_data_d = out_data_d ^ {OUT_W{in_data[0]}};
`endif
  end

  assign sig_d       = {sig_q[SIG_W-2:0], sig_q[SIG_W-1] ^ sig_q[2] ^ sig_q[0]}
                       ^ SIG_W'(out_data_q);
  assign accept      = (state_q == RUN) && in_valid && in_ready_q;
  assign acc_cnt_inc = acc_cnt_q + CNT_W'(1);
  assign upd_cnt_inc = upd_cnt_q + CNT_W'(1);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sig_q       <= '0;
      done_q      <= 1'b0;
      acc_cnt_q   <= '0;
      upd_cnt_q   <= '0;
      num_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_q     <= '0;
            acc_cnt_q <= '0;
            upd_cnt_q <= '0;
            num_q     <= num_samples;
            if (num_samples != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_q   <= acc_cnt_inc;
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            if (acc_cnt_inc == num_q) in_ready_q <= 1'b0;
          end
          // The run ends on the last signature update, one edge after the last accept.
          if (out_valid_q) begin
            sig_q     <= sig_d;
            upd_cnt_q <= upd_cnt_inc;
            if (upd_cnt_inc == num_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sig       = sig_q;
  assign done      = done_q;

endmodule

// File: tb/tb_casez_lut_sig.sv
// Self-checking bench for casez_lut_sig: directed vector table, LFSR and random
// streams scored against a queue-based reference model, and mid-run reset.
module tb_casez_lut_sig;

  logic        clk;
  logic        reset_l;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic [0:0]  out_data;
  logic [63:0] sig;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [63:0] tb_lut = 64'h29_8593_2C4D;
  logic [63:0] lfsr;

  casez_lut_sig dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .start      (start),
    .num_samples(num_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sig        (sig),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        exp_out;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference decode: entry number from the mode rules, then a table lookup.
  function automatic logic model_out(input logic [23:0] w);
    int e;
    logic b;
    if (w[17:16] == 2'b00)      e = int'(w[2:0]);
    else if (w[17:16] == 2'b01) e = 10 + int'(w[2:0]);
    else if (w[4])              e = 20 + int'(w[2:0]);
    else                        e = 30 + int'(w[2:0]);
    b = tb_lut[e];
`ifdef CASEZ_LUT_SIG_XOR_EN
    if (w[17:16] == 2'b00) b = b ^ w[0];
`endif
    return b;
  endfunction

  function automatic logic [63:0] misr(input logic [63:0] s, input logic d);
    return {s[62:0], s[63] ^ s[2] ^ s[0]} ^ {63'b0, d};
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, " in_ready"},  64'(in_ready),  64'd0);
    check({nm, " out_valid"}, 64'(out_valid), 64'd0);
    check({nm, " out_data"},  64'(out_data),  64'd0);
    check({nm, " sig"},       sig,            64'd0);
    check({nm, " done"},      64'(done),      64'd0);
  endtask

  task automatic run_one(input logic [23:0] d, input logic e, input string nm);
    @(negedge clk);
    num_samples = 16'd1; start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    check({nm, " done clr"}, 64'(done), 64'd0);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " out_valid"}, 64'(out_valid), 64'd1);
    check({nm, " out_data"},  64'(out_data),  64'(e));
    check({nm, " in_ready lo"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({nm, " done"}, 64'(done), 64'd1);
    check({nm, " sig"},  sig,       64'(e));
    check({nm, " pulse end"}, 64'(out_valid), 64'd0);
  endtask

  task automatic stream(input int n, input bit gaps, input bit use_lfsr,
                        input bit poke_start, input string nm);
    logic [23:0] q[$];
    logic [63:0] msig;
    logic [23:0] d;
    logic        e;
    int          acc, pulses;
    bit          prev_acc, fin, pending;
    msig = '0; acc = 0; pulses = 0; prev_acc = 0; fin = 0; pending = 0;
    @(negedge clk);
    num_samples = 16'(n); start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check({nm, " ready at start"}, 64'(in_ready), 64'd1);
    check({nm, " done at start"},  64'(done),     64'd0);
    for (int cyc = 0; cyc < 4 * n + 20 && !fin; cyc++) begin
      start = 1'b0; num_samples = 16'(n);
      if (poke_start && pulses < n && ($urandom % 4) == 0) begin
        start = 1'b1; num_samples = 16'($urandom);
      end
      in_valid = gaps ? (($urandom % 3) != 0) : 1'b1;
      in_data  = use_lfsr ? lfsr[23:0] : 24'($urandom);
      prev_acc = in_valid && in_ready;
      if (prev_acc) begin
        q.push_back(in_data);
        acc++;
        if (use_lfsr) lfsr = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
      end
      @(negedge clk);
      if (pending) begin
        check({nm, " done"},      64'(done), 64'd1);
        check({nm, " final sig"}, sig,       msig);
        fin = 1;
      end else begin
        check({nm, " out_valid"}, 64'(out_valid), 64'(prev_acc));
        if (prev_acc) begin
          d = q.pop_front();
          e = model_out(d);
          check({nm, " out_data"}, 64'(out_data), 64'(e));
          msig = misr(msig, e);
          pulses++;
          if (pulses == n) pending = 1;
        end
        check({nm, " done early"}, 64'(done), 64'd0);
        check({nm, " in_ready"}, 64'(in_ready), 64'(acc < n));
      end
    end
    start = 1'b0; in_valid = 1'b0; num_samples = 16'(n);
    check({nm, " finished"}, 64'(fin), 64'd1);
    check({nm, " pulse count"}, 64'(pulses), 64'(n));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check({nm, " done held"}, 64'(done), 64'd1);
      check({nm, " sig held"},  sig,       msig);
      check({nm, " no pulse"},  64'(out_valid), 64'd0);
    end
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{24'h010000, 1'b1};
`ifdef CASEZ_LUT_SIG_XOR_EN
    vecs[1]  = '{24'h000001, 1'b1};
    vecs[8]  = '{24'h000003, 1'b0};
`else
    vecs[1]  = '{24'h000001, 1'b0};
    vecs[8]  = '{24'h000003, 1'b1};
`endif
    vecs[2]  = '{24'h000000, 1'b1};
    vecs[3]  = '{24'h030010, 1'b1};
    vecs[4]  = '{24'h030000, 1'b0};
    vecs[5]  = '{24'hFF0010, 1'b1};
    vecs[6]  = '{24'hFF0000, 1'b0};
    vecs[7]  = '{24'h01FFE5, 1'b0};
    vecs[9]  = '{24'h020017, 1'b0};
    vecs[10] = '{24'h030005, 1'b1};
    vecs[11] = '{24'hA8FFEA, 1'b1};

    reset_l = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_l = 1'b1;

    for (int i = 0; i < 12; i++) run_one(vecs[i].data, vecs[i].exp_out, $sformatf("vec%0d", i));

    lfsr = 64'h97;
    stream(90, 1'b0, 1'b1, 1'b0, "lfsr90");
    for (int r = 0; r < 4; r++) stream(8, 1'b1, 1'b0, 1'b1, $sformatf("gap8_%0d", r));
    stream(40, 1'b1, 1'b0, 1'b0, "gap40");

    // Reset in the middle of a run with one sample still in flight.
    @(negedge clk);
    num_samples = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 24'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrun pulse", 64'(out_valid), 64'd1);
    #2 reset_l = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    check_all_zero("after reset");
    num_samples = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero run done",  64'(done),      64'd1);
    check("zero run sig",   sig,            64'd0);
    check("zero run pulse", 64'(out_valid), 64'd0);
    check("zero run ready", 64'(in_ready),  64'd0);
    in_valid = 1'b1; in_data = 24'h010000;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero run no accept", 64'(out_valid), 64'd0);
    check("zero run done held", 64'(done),      64'd1);

    stream(8, 1'b1, 1'b0, 1'b1, "recover8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/casez_lut_sig.md
# casez_lut_sig

Parametrised, registered nested-casez lookup engine with a signature accumulator. It is used as a self-checking decode block in regression designs. It accepts input words through a valid/ready handshake and decodes a mode field plus a 3-bit selector into an OUT_W-bit entry of a constant lookup table. Each result is registered, then folded into a SIG_W-bit MISR. After a programmed number of samples it reports done with the final signature.

## Interface
- IN_W, 24, input word width; must be ≥ 18
- OUT_W, 1, lookup entry width (lanes)
- SIG_W, 64, signature width; must be ≥ OUT_W and ≥ 3
- CNT_W, 16, sample counter width
- LUT, 1024-bit constant, lookup table; entry e, lane l = LUT[e*OUT_W + l]; must hold ≥ 38*OUT_W bits
- clk  input  1  clock; all state on rising edge
- reset_l  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- num_samples  input  CNT_W  samples per run; latched on start
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data
- in_data  input  IN_W  sample word
- out_valid  output  1  out_data valid (one-cycle pulse per sample)
- out_data  output  OUT_W  decoded entry
- sig  output  SIG_W  running signature
- done  output  1  run complete; held until next start

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 and num_samples≠0 → RUN; this clears sig and both counters and latches num_samples.
  - start with num_samples=0 → DONE, sig cleared.
- RUN: in_ready=1 until accepted count == latched num_samples, then 0.
  - An accept is a cycle with in_valid & in_ready.
  - When the MISR update count reaches num_samples, the FSM moves to DONE.
- start is ignored while in RUN.
- Decode uses casez on in_data[17:16]:
  - 2'b00: entry = in_data[2:0]
  - 2'b01: entry = 10 + in_data[2:0]
  - 2'b1?: entry = 20 + in_data[2:0] if in_data[4] = 1, else 30 + in_data[2:0]
- Every case arm is fully specified, with no latch and no X.
- MISR on each out_valid: sig ← {sig[SIG_W-2:0], sig[SIG_W-1]^sig[2]^sig[0]} ^ zero-extended out_data.
- Bits of in_data other than [17:16], [4] and [2:0] are ignored.

## Timing
- Reset values: FSM=IDLE; in_ready, out_valid, out_data, sig, done and counters all 0.
- Latency: accept at edge k → out_valid=1 and out_data valid during cycle k..k+1. sig reflects that sample after edge k+1.
- Throughput: one sample per cycle. Back-to-back accepts produce back-to-back out_valid.
- The last accept at edge k gives in_ready=0 after edge k and done=1 after edge k+1, with sig final in the same cycle.
- done stays high and sig stays stable until the next start; the start edge clears done.
- Reset asserted mid-run: everything returns to reset values immediately (asynchronously). An in-flight sample is discarded.
- Counter wrap: not possible, because accepts stop at num_samples ≤ 2^CNT_W−1.

## Configuration
- CASEZ_LUT_SIG_XOR_EN defined: in mode 2'b00 each lane is LUT bit ^ in_data[0].
- Undefined: mode 2'b00 returns the raw LUT bit, like the other modes.
- Both builds share the same interface and timing.

## Test plan
- Reset: hold reset_l=0 and check all outputs 0. Release, start with num_samples=1 and in_data=24'h010000 → out_data=LUT[10]=1 one cycle after accept. done=1 next cycle, with sig=1.
- XOR_EN on, in_data=24'h000001 → out_data = 1^LUT[1] = 1. XOR_EN off → out_data=0. in_data=0 gives 1 in both builds.
- Mode 2'b1?: in_data=24'h030010 → entry 20. Changing only bit 4 to 0 (24'h030000) → entry 30. Bits [23:18] toggled give no change.
- Streaming: num_samples=90 with a 64-bit LFSR-driven in_data[23:0] (seed 64'h97, in_valid held high) → 90 consecutive out_valid pulses, in_ready low after the 90th accept. Final sig matches the golden model, with done=1 exactly one cycle later.
- Handshake gaps: randomly deassert in_valid, num_samples=8 → exactly 8 out_valid pulses, no sample lost or duplicated. Asserting start during RUN has no effect.
- Reset mid-run after 3 of 8 samples → outputs 0 immediately. A new start with num_samples=0 → DONE with sig=0, no out_valid.
